dprintf_byte_writer: RTL and testbench



---
 rtl/dprintf_pkg.sv | 40 ++++
 rtl/dprintf_hex_char.sv | 22 ++
 rtl/dprintf_byte_writer.sv | 166 ++++++++++++++++
 tb/tb_dprintf_byte_writer.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dprintf_pkg.sv
// -----------------------------------------------------------------------------
// dprintf_pkg
// Shared types and constants for the dprintf byte writer.
//   t_dprintf_req_4  : request from the APB dprintf requester (address + 32 bytes)
//   t_dprintf_byte   : one character write toward the framebuffer SRAM
//   t_dprintf_state  : writer FSM state, also exported for observation
// Format codes inside the 32-byte stream:
//   0x00             end of string
//   0x81..0x84       print the next 1..4 bytes as uppercase hex
//   0x01..0x7F       literal character
//   anything else    ignored
// -----------------------------------------------------------------------------
package dprintf_pkg;

   localparam logic [7:0] DPRINTF_END           = 8'h00;
   localparam logic [7:0] DPRINTF_HEX_BASE      = 8'h80;
   localparam logic [7:0] DPRINTF_HEX_MAX_BYTES = 8'd4;

   typedef struct packed {
      logic        valid;
      logic [15:0] address;
      logic [63:0] data_0;
      logic [63:0] data_1;
      logic [63:0] data_2;
      logic [63:0] data_3;
   } t_dprintf_req_4;

   typedef struct packed {
      logic        valid;
      logic [15:0] address;
      logic [7:0]  data;
   } t_dprintf_byte;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SCAN = 2'd1,
      ST_HEX  = 2'd2
   } t_dprintf_state;

endpackage

// File: rtl/dprintf_hex_char.sv
// -----------------------------------------------------------------------------
// dprintf_hex_char
// Converts a 4-bit nybble into its uppercase ASCII hex digit.
// Ports:
//   i_nybble : value 0..15
//   o_char   : '0'..'9' (0x30..0x39) or 'A'..'F' (0x41..0x46)
// -----------------------------------------------------------------------------
module dprintf_hex_char (
   input  logic [3:0] i_nybble,
   output logic [7:0] o_char
);

   always_comb begin
      if (i_nybble < 4'd10) begin
         o_char = 8'h30 + {4'h0, i_nybble};
      end else begin
         // 0x37 + 10 = 0x41 = 'A'
         o_char = 8'h37 + {4'h0, i_nybble};
      end
   end

endmodule

// File: rtl/dprintf_byte_writer.sv
// -----------------------------------------------------------------------------
// dprintf_byte_writer
// Takes a 32-byte compact format string from the dprintf requester and turns it
// into a stream of single-character writes, one per cycle when the sink is
// ready.
// Ports:
//   clk, clk__enable          : clock and clock enable (all state holds when low)
//   reset                     : asynchronous, active-high
//   dprintf_req__*            : request (valid, start address, four data words)
//   dprintf_ack               : one-cycle accept pulse back to the requester
//   byte_wr__valid/address/data, byte_wr_ready : character write output
//   dbg_state                 : current FSM state
//
// Handshake: a write transfers on a clock edge where byte_wr__valid and
// byte_wr_ready are both high (with clk__enable high). While valid is high and
// ready is low, address and data are held unchanged. The writer only loads a
// new character into the output register when that register is empty or is
// being drained on the same edge ("slot free").
// -----------------------------------------------------------------------------
module dprintf_byte_writer
   import dprintf_pkg::*;
(
   input  logic           clk,
   input  logic           clk__enable,
   input  logic           reset,
   input  logic           dprintf_req__valid,
   input  logic [15:0]    dprintf_req__address,
   input  logic [63:0]    dprintf_req__data_0,
   input  logic [63:0]    dprintf_req__data_1,
   input  logic [63:0]    dprintf_req__data_2,
   input  logic [63:0]    dprintf_req__data_3,
   output logic           dprintf_ack,
   output logic           byte_wr__valid,
   output logic [15:0]    byte_wr__address,
   output logic [7:0]     byte_wr__data,
   input  logic           byte_wr_ready,
   output t_dprintf_state dbg_state
);

   t_dprintf_req_4  w_req;
   t_dprintf_state  r_state;
   // Element 0 is the most significant byte, so byte 0 = data_0[63:56].
   logic [0:31][7:0] r_data;
   logic [4:0]       r_index;
   logic [15:0]      r_addr;
   logic [3:0]       r_hex_count;
   t_dprintf_byte    r_wr;

   logic       w_slot_free;
   logic [7:0] w_byte;
   logic       w_last;
   logic       w_is_hex;
   logic [3:0] w_nybble;
   logic [7:0] w_hex_char;

   always_comb begin
      w_req.valid   = dprintf_req__valid;
      w_req.address = dprintf_req__address;
      w_req.data_0  = dprintf_req__data_0;
      w_req.data_1  = dprintf_req__data_1;
      w_req.data_2  = dprintf_req__data_2;
      w_req.data_3  = dprintf_req__data_3;
   end

   assign dprintf_ack = (r_state == ST_IDLE) & w_req.valid;

   assign w_slot_free = !r_wr.valid | byte_wr_ready;
   assign w_byte      = r_data[r_index];
   assign w_last      = (r_index == 5'd31);
   assign w_is_hex    = (w_byte > DPRINTF_HEX_BASE) &&
                        (w_byte <= (DPRINTF_HEX_BASE + DPRINTF_HEX_MAX_BYTES));
   // Even count -> high nybble first, odd count -> low nybble.
   assign w_nybble    = r_hex_count[0] ? w_byte[3:0] : w_byte[7:4];

   dprintf_hex_char u_hex_char (
      .i_nybble (w_nybble),
      .o_char   (w_hex_char)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_data      <= '0;
         r_index     <= '0;
         r_addr      <= '0;
         r_hex_count <= '0;
         r_wr        <= '0;
      end else if (clk__enable) begin
         // Drained or empty slot becomes empty unless a new character lands below.
         if (w_slot_free) begin
            r_wr.valid <= 1'b0;
         end

         case (r_state)
            ST_IDLE: begin
               // A last write may still be waiting in r_wr; capturing here is
               // safe because SCAN will not overwrite it until the slot frees.
               if (dprintf_ack) begin
                  r_addr      <= w_req.address;
                  r_data      <= {w_req.data_0, w_req.data_1, w_req.data_2, w_req.data_3};
                  r_index     <= '0;
                  r_hex_count <= '0;
                  r_state     <= ST_SCAN;
               end
            end

            ST_SCAN: begin
               if (w_slot_free) begin
                  if (w_byte == DPRINTF_END) begin
                     r_state <= ST_IDLE;
                  end else begin
                     if (!w_byte[7]) begin
                        r_wr.valid   <= 1'b1;
                        r_wr.address <= r_addr;
                        r_wr.data    <= w_byte;
                        r_addr       <= r_addr + 16'd1;
                     end else if (w_is_hex) begin
                        r_hex_count <= {w_byte[2:0], 1'b0};
                     end
                     // A hex code in the final byte has nothing left to print.
                     if (w_last) begin
                        r_state <= ST_IDLE;
                     end else begin
                        r_index <= r_index + 5'd1;
                        if (w_is_hex) begin
                           r_state <= ST_HEX;
                        end
                     end
                  end
               end
            end

            ST_HEX: begin
               if (w_slot_free) begin
                  r_wr.valid   <= 1'b1;
                  r_wr.address <= r_addr;
                  r_wr.data    <= w_hex_char;
                  r_addr       <= r_addr + 16'd1;
                  r_hex_count  <= r_hex_count - 4'd1;
                  // Byte fully printed after its low nybble.
                  if (r_hex_count[0]) begin
                     if (w_last) begin
                        r_state <= ST_IDLE;
                     end else begin
                        r_index <= r_index + 5'd1;
                        if (r_hex_count == 4'd1) begin
                           r_state <= ST_SCAN;
                        end
                     end
                  end
               end
            end

            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign byte_wr__valid   = r_wr.valid;
   assign byte_wr__address = r_wr.address;
   assign byte_wr__data    = r_wr.data;
   assign dbg_state        = r_state;

endmodule

// File: tb/tb_dprintf_byte_writer.sv
module tb_dprintf_byte_writer;
  import dprintf_pkg::*;

  // ---------------- clock / reset ----------------
  logic           clk;
  logic           clk__enable;
  logic           reset;
  logic           dprintf_req__valid;
  logic [15:0]    dprintf_req__address;
  logic [63:0]    dprintf_req__data_0;
  logic [63:0]    dprintf_req__data_1;
  logic [63:0]    dprintf_req__data_2;
  logic [63:0]    dprintf_req__data_3;
  logic           dprintf_ack;
  logic           byte_wr__valid;
  logic [15:0]    byte_wr__address;
  logic [7:0]     byte_wr__data;
  logic           byte_wr_ready;
  t_dprintf_state dbg_state;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;

  logic [23:0] exp_q[$];
  logic [23:0] obs_q[$];
  int          obs_cyc[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dprintf_byte_writer dut (
    .clk                  (clk),
    .clk__enable          (clk__enable),
    .reset                (reset),
    .dprintf_req__valid   (dprintf_req__valid),
    .dprintf_req__address (dprintf_req__address),
    .dprintf_req__data_0  (dprintf_req__data_0),
    .dprintf_req__data_1  (dprintf_req__data_1),
    .dprintf_req__data_2  (dprintf_req__data_2),
    .dprintf_req__data_3  (dprintf_req__data_3),
    .dprintf_ack          (dprintf_ack),
    .byte_wr__valid       (byte_wr__valid),
    .byte_wr__address     (byte_wr__address),
    .byte_wr__data        (byte_wr__data),
    .byte_wr_ready        (byte_wr_ready),
    .dbg_state            (dbg_state)
  );

  // Inputs change 2 time units after posedge; the monitor samples on negedge.
  always @(negedge clk) begin
    if (!reset && clk__enable && byte_wr__valid && byte_wr_ready) begin
      obs_q.push_back({byte_wr__address, byte_wr__data});
      obs_cyc.push_back(cyc);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_req(input logic [15:0] a, input logic [63:0] d0, input logic [63:0] d1,
                          input logic [63:0] d2, input logic [63:0] d3,
                          output logic ack_before, output logic ack_after);
    dprintf_req__valid   = 1'b1;
    dprintf_req__address = a;
    dprintf_req__data_0  = d0;
    dprintf_req__data_1  = d1;
    dprintf_req__data_2  = d2;
    dprintf_req__data_3  = d3;
    @(negedge clk);
    ack_before = dprintf_ack;
    @(posedge clk);
    #1;
    ack_after = dprintf_ack;
    #1;
    dprintf_req__valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      #2;
      if (dbg_state == ST_IDLE && !byte_wr__valid) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic clear_sb();
    exp_q.delete();
    obs_q.delete();
    obs_cyc.delete();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #1;
    tests_run++;
    if (byte_wr__valid !== 1'b0 || byte_wr__address !== 16'h0 || byte_wr__data !== 8'h0) begin
      $display("FAIL reset_outputs got v=%b a=%h d=%h want v=0 a=0000 d=00",
               byte_wr__valid, byte_wr__address, byte_wr__data);
      tests_failed++;
    end
    tests_run++;
    if (dbg_state !== ST_IDLE || dprintf_ack !== 1'b0) begin
      $display("FAIL reset_state got state=%0d ack=%b want state=0 ack=0", dbg_state, dprintf_ack);
      tests_failed++;
    end
    @(posedge clk);
    @(posedge clk);
    #2;
    reset = 1'b0;
  endtask

  task automatic test_hello();
    logic ab, aa;
    bit ok;
    clear_sb();
    for (int i = 0; i < 5; i++) exp_q.push_back({16'h0100 + 16'(i), 8'h00});
    exp_q[0][7:0] = 8'h48; exp_q[1][7:0] = 8'h65; exp_q[2][7:0] = 8'h6C;
    exp_q[3][7:0] = 8'h6C; exp_q[4][7:0] = 8'h6F;
    send_req(16'h0100, 64'h48656C6C6F000000, 64'h0, 64'h0, 64'h0, ab, aa);
    tests_run++;
    if (ab !== 1'b1 || aa !== 1'b0) begin
      $display("FAIL hello_ack_pulse got before=%b after=%b want before=1 after=0", ab, aa);
      tests_failed++;
    end
    wait_idle(40, ok);
    tests_run++;
    if (!ok) begin $display("FAIL hello_idle got timeout want idle"); tests_failed++; end
    tests_run++;
    if (obs_q.size() !== exp_q.size()) begin
      $display("FAIL hello_count got %0d want %0d", obs_q.size(), exp_q.size());
      tests_failed++;
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      tests_run++;
      if (obs_q[i] !== exp_q[i]) begin
        $display("FAIL hello_wr%0d got %h want %h", i, obs_q[i], exp_q[i]);
        tests_failed++;
      end
    end
    for (int i = 1; i < obs_cyc.size(); i++) begin
      tests_run++;
      if (obs_cyc[i] !== obs_cyc[i-1] + 1) begin
        $display("FAIL hello_gap%0d got %0d want 1", i, obs_cyc[i] - obs_cyc[i-1]);
        tests_failed++;
      end
    end
  endtask

  task automatic test_hex();
    logic ab, aa;
    bit ok;
    logic [7:0] chars [8];
    chars = '{8'h41, 8'h44, 8'h45, 8'h41, 8'h44, 8'h42, 8'h45, 8'h42};
    clear_sb();
    for (int i = 0; i < 8; i++) exp_q.push_back({16'h0010 + 16'(i), chars[i]});
    send_req(16'h0010, 64'h4183DEADBE420000, 64'h0, 64'h0, 64'h0, ab, aa);
    wait_idle(40, ok);
    tests_run++;
    if (!ok) begin $display("FAIL hex_idle got timeout want idle"); tests_failed++; end
    tests_run++;
    if (obs_q.size() !== exp_q.size()) begin
      $display("FAIL hex_count got %0d want %0d", obs_q.size(), exp_q.size());
      tests_failed++;
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      tests_run++;
      if (obs_q[i] !== exp_q[i]) begin
        $display("FAIL hex_wr%0d got %h want %h", i, obs_q[i], exp_q[i]);
        tests_failed++;
      end
    end
    if (obs_cyc.size() == 8) begin
      tests_run++;
      if (obs_cyc[1] - obs_cyc[0] !== 2) begin
        $display("FAIL hex_bubble got gap %0d want 2", obs_cyc[1] - obs_cyc[0]);
        tests_failed++;
      end
      tests_run++;
      if (obs_cyc[7] - obs_cyc[1] !== 6) begin
        $display("FAIL hex_stream got span %0d want 6", obs_cyc[7] - obs_cyc[1]);
        tests_failed++;
      end
    end
  endtask

  task automatic test_stall();
    logic ab, aa;
    bit ok;
    logic [7:0] chars [5];
    chars = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F};
    clear_sb();
    for (int i = 0; i < 5; i++) exp_q.push_back({16'h0100 + 16'(i), chars[i]});
    send_req(16'h0100, 64'h48656C6C6F000000, 64'h0, 64'h0, 64'h0, ab, aa);
    @(posedge clk); #2;      // 'H' now valid
    @(posedge clk); #2;      // 'e' now valid
    byte_wr_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests_run++;
      if (byte_wr__valid !== 1'b1 || byte_wr__address !== 16'h0101 || byte_wr__data !== 8'h65) begin
        $display("FAIL stall_hold%0d got v=%b a=%h d=%h want v=1 a=0101 d=65",
                 i, byte_wr__valid, byte_wr__address, byte_wr__data);
        tests_failed++;
      end
    end
    @(posedge clk); #2;
    byte_wr_ready = 1'b1;
    wait_idle(40, ok);
    tests_run++;
    if (!ok) begin $display("FAIL stall_idle got timeout want idle"); tests_failed++; end
    tests_run++;
    if (obs_q.size() !== exp_q.size()) begin
      $display("FAIL stall_count got %0d want %0d", obs_q.size(), exp_q.size());
      tests_failed++;
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      tests_run++;
      if (obs_q[i] !== exp_q[i]) begin
        $display("FAIL stall_wr%0d got %h want %h", i, obs_q[i], exp_q[i]);
        tests_failed++;
      end
    end
  endtask

  task automatic test_wrap();
    logic ab, aa;
    bit ok;
    clear_sb();
    for (int i = 0; i < 32; i++) exp_q.push_back({16'hFFFE + 16'(i), 8'h2A});
    send_req(16'hFFFE, {8{8'h2A}}, {8{8'h2A}}, {8{8'h2A}}, {8{8'h2A}}, ab, aa);
    wait_idle(100, ok);
    tests_run++;
    if (!ok) begin $display("FAIL wrap_idle got timeout want idle"); tests_failed++; end
    tests_run++;
    if (obs_q.size() !== exp_q.size()) begin
      $display("FAIL wrap_count got %0d want %0d", obs_q.size(), exp_q.size());
      tests_failed++;
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      tests_run++;
      if (obs_q[i] !== exp_q[i]) begin
        $display("FAIL wrap_wr%0d got %h want %h", i, obs_q[i], exp_q[i]);
        tests_failed++;
      end
    end
    if (obs_cyc.size() == 32) begin
      tests_run++;
      if (obs_cyc[31] - obs_cyc[0] !== 31) begin
        $display("FAIL wrap_rate got span %0d want 31", obs_cyc[31] - obs_cyc[0]);
        tests_failed++;
      end
    end
  endtask

  task automatic test_truncate();
    logic ab, aa;
    bit ok;
    clear_sb();
    exp_q.push_back({16'h2000, 8'h58});
    exp_q.push_back({16'h2001, 8'h59});
    exp_q.push_back({16'h2002, 8'h31});
    exp_q.push_back({16'h2003, 8'h32});
    send_req(16'h2000, 64'h8058FF80FF5980FF, 64'h80FF80FF80FF80FF,
             64'h80FF80FF80FF80FF, 64'h80FF80FF80FF8412, ab, aa);
    wait_idle(100, ok);
    tests_run++;
    if (!ok) begin $display("FAIL trunc_idle got timeout want idle"); tests_failed++; end
    tests_run++;
    if (obs_q.size() !== exp_q.size()) begin
      $display("FAIL trunc_count got %0d want %0d", obs_q.size(), exp_q.size());
      tests_failed++;
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      tests_run++;
      if (obs_q[i] !== exp_q[i]) begin
        $display("FAIL trunc_wr%0d got %h want %h", i, obs_q[i], exp_q[i]);
        tests_failed++;
      end
    end
  endtask

  task automatic test_clk_enable();
    logic ab, aa;
    bit ok;
    logic [23:0] held;
    logic [7:0] chars [5];
    chars = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F};
    clear_sb();
    for (int i = 0; i < 5; i++) exp_q.push_back({16'h0400 + 16'(i), chars[i]});
    send_req(16'h0400, 64'h48656C6C6F000000, 64'h0, 64'h0, 64'h0, ab, aa);
    @(posedge clk); #2;
    @(posedge clk); #2;
    clk__enable = 1'b0;
    held = {byte_wr__address, byte_wr__data};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests_run++;
      if (byte_wr__valid !== 1'b1 || {byte_wr__address, byte_wr__data} !== 24'h040165) begin
        $display("FAIL cen_hold%0d got v=%b %h want v=1 040165", i, byte_wr__valid,
                 {byte_wr__address, byte_wr__data});
        tests_failed++;
      end
    end
    @(posedge clk); #2;
    clk__enable = 1'b1;
    wait_idle(40, ok);
    tests_run++;
    if (!ok) begin $display("FAIL cen_idle got timeout want idle"); tests_failed++; end
    tests_run++;
    if (obs_q.size() !== exp_q.size()) begin
      $display("FAIL cen_count got %0d want %0d (held %h)", obs_q.size(), exp_q.size(), held);
      tests_failed++;
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      tests_run++;
      if (obs_q[i] !== exp_q[i]) begin
        $display("FAIL cen_wr%0d got %h want %h", i, obs_q[i], exp_q[i]);
        tests_failed++;
      end
    end
  endtask

  task automatic test_mid_reset();
    logic ab, aa;
    bit ok;
    bit reached;
    clear_sb();
    send_req(16'hFFFE, {8{8'h2A}}, {8{8'h2A}}, {8{8'h2A}}, {8{8'h2A}}, ab, aa);
    reached = 1'b0;
    for (int i = 0; i < 40 && !reached; i++) begin
      @(posedge clk); #2;
      if (obs_q.size() >= 10) reached = 1'b1;
    end
    tests_run++;
    if (!reached) begin $display("FAIL mreset_reach got %0d writes want 10", obs_q.size()); tests_failed++; end
    tests_run++;
    if (byte_wr__valid !== 1'b1) begin
      $display("FAIL mreset_inflight got v=%b want v=1", byte_wr__valid);
      tests_failed++;
    end
    reset = 1'b1;
    #1;
    tests_run++;
    if (byte_wr__valid !== 1'b0 || byte_wr__address !== 16'h0 || byte_wr__data !== 8'h0 ||
        dbg_state !== ST_IDLE) begin
      $display("FAIL mreset_clear got v=%b a=%h d=%h state=%0d want v=0 a=0000 d=00 state=0",
               byte_wr__valid, byte_wr__address, byte_wr__data, dbg_state);
      tests_failed++;
    end
    @(posedge clk); #2;
    reset = 1'b0;
    clear_sb();
    exp_q.push_back({16'h0300, 8'h48});
    exp_q.push_back({16'h0301, 8'h69});
    send_req(16'h0300, 64'h4869000000000000, 64'h0, 64'h0, 64'h0, ab, aa);
    tests_run++;
    if (ab !== 1'b1) begin $display("FAIL mreset_ack got %b want 1", ab); tests_failed++; end
    wait_idle(40, ok);
    tests_run++;
    if (!ok || obs_q.size() !== exp_q.size()) begin
      $display("FAIL mreset_count got %0d (idle=%0d) want %0d", obs_q.size(), ok, exp_q.size());
      tests_failed++;
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      tests_run++;
      if (obs_q[i] !== exp_q[i]) begin
        $display("FAIL mreset_wr%0d got %h want %h", i, obs_q[i], exp_q[i]);
        tests_failed++;
      end
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    reset                = 1'b1;
    clk__enable          = 1'b1;
    byte_wr_ready        = 1'b1;
    dprintf_req__valid   = 1'b0;
    dprintf_req__address = 16'h0;
    dprintf_req__data_0  = 64'h0;
    dprintf_req__data_1  = 64'h0;
    dprintf_req__data_2  = 64'h0;
    dprintf_req__data_3  = 64'h0;
    test_reset();
    test_hello();
    test_hex();
    test_stall();
    test_wrap();
    test_truncate();
    test_clk_enable();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
